// File: rtl/tex_flash_if.sv
// tex_flash_if: texture SPI link between the SPI master side (which also
// owns the asynchronous byte memory) and the flash responder.
//
// Signals (named from the responder's point of view):
//   i_csb       chip select, active low
//   i_mosi      serial command/address bit
//   o_miso      serial data bit, MSB first
//   o_miso_oe   MISO output enable, high during the data phase
//   o_mem_addr  byte address into the external memory (ADDR_BITS wide)
//   i_mem_data  byte at o_mem_addr, same-cycle read
//   o_active    transaction in progress
//   o_bad_cmd   one-cycle pulse on an unsupported command byte
//
// master modport: SPI master plus memory model. slave modport: responder.
interface tex_flash_if #(
  parameter int ADDR_BITS = 12
) ();
  logic                 i_csb;
  logic                 i_mosi;
  logic                 o_miso;
  logic                 o_miso_oe;
  logic [ADDR_BITS-1:0] o_mem_addr;
  logic [7:0]           i_mem_data;
  logic                 o_active;
  logic                 o_bad_cmd;

  modport master (
    output i_csb, i_mosi, i_mem_data,
    input  o_miso, o_miso_oe, o_mem_addr, o_active, o_bad_cmd
  );

  modport slave (
    input  i_csb, i_mosi, i_mem_data,
    output o_miso, o_miso_oe, o_mem_addr, o_active, o_bad_cmd
  );
endinterface

// File: rtl/tex_flash_responder.sv
// tex_flash_responder: device end of the texture SPI link, emulating a
// serial flash. Decodes READ (03h) and, when the macro
// TEX_RESP_FAST_READ_EN is defined, FAST READ (0Bh, 8 dummy clocks).
// Bytes are fetched from an external asynchronous memory and streamed
// MSB first on MISO with auto-increment and wrap at 2^ADDR_BITS.
//
// Ports:
//   clk      texture SCLK, free running; all state moves on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      tex_flash_if.slave (csb, mosi, miso, miso_oe, memory port,
//            active and bad-command status)
//
// Configuration macro: TEX_RESP_FAST_READ_EN (undefined: 0Bh is rejected
// like any other unsupported command and no DUMMY logic is built).
module tex_flash_responder #(
  parameter int ADDR_BITS = 12
) (
  input logic        clk,
  input logic        reset_n,
  tex_flash_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, IGNORE
  } state_t;

  state_t               state, state_d;
  logic [5:0]           cnt, cnt_d;
  logic [6:0]           cmd_sr, cmd_sr_d;
  logic [ADDR_BITS-2:0] addr_sr, addr_sr_d;
  logic [7:0]           data_sr, data_sr_d;
  logic [ADDR_BITS-1:0] ptr, ptr_d;
  logic                 armed, armed_d;
  logic                 bad, bad_d;
  logic                 miso, miso_d;
  logic                 fast_sel;
  logic [7:0]           cmd_full;
  logic [ADDR_BITS-1:0] addr_full;
  logic [ADDR_BITS-1:0] mem_addr;

`ifdef TEX_RESP_FAST_READ_EN
  logic is_fast, is_fast_d;
  assign fast_sel = is_fast;
`else
  assign fast_sel = 1'b0;
`endif

  // The bit arriving this edge completes the command / address word, so
  // decisions at edges 7 and 31 use these rather than the registers alone.
  // Address bits above ADDR_BITS simply shift out of the register.
  assign cmd_full  = {cmd_sr, bus.i_mosi};
  assign addr_full = {addr_sr, bus.i_mosi};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      ptr     <= '0;
      armed   <= 1'b0;
      bad     <= 1'b0;
      miso    <= 1'b0;
`ifdef TEX_RESP_FAST_READ_EN
      is_fast <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd_sr  <= cmd_sr_d;
      addr_sr <= addr_sr_d;
      data_sr <= data_sr_d;
      ptr     <= ptr_d;
      armed   <= armed_d;
      bad     <= bad_d;
      miso    <= miso_d;
`ifdef TEX_RESP_FAST_READ_EN
      is_fast <= is_fast_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cmd_sr_d  = cmd_sr;
    addr_sr_d = addr_sr;
    data_sr_d = data_sr;
    ptr_d     = ptr;
    armed_d   = armed;
    bad_d     = 1'b0;
    mem_addr  = ptr;
`ifdef TEX_RESP_FAST_READ_EN
    is_fast_d = is_fast;
`endif

    if (bus.i_csb) begin
      // Deselect overrides everything, including a bad-command pulse due
      // on this edge. Seeing csb high also arms decoding after a reset.
      state_d = IDLE;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            cmd_sr_d = {6'b0, bus.i_mosi};
            cnt_d    = 6'd1;
            state_d  = CMD;
          end else begin
            // Reset released mid-transaction: stay silent until csb toggles.
            state_d = IGNORE;
          end
        end

        CMD: begin
          cmd_sr_d = cmd_full[6:0];
          cnt_d    = cnt + 6'd1;
          if (cnt == 6'd7) begin
            if (cmd_full == 8'h03) begin
              state_d = ADDR;
`ifdef TEX_RESP_FAST_READ_EN
              is_fast_d = 1'b0;
            end else if (cmd_full == 8'h0B) begin
              state_d   = ADDR;
              is_fast_d = 1'b1;
`endif
            end else begin
              state_d = IGNORE;
              bad_d   = 1'b1;
            end
          end
        end

        ADDR: begin
          addr_sr_d = addr_full[ADDR_BITS-2:0];
          cnt_d     = cnt + 6'd1;
          if (cnt == 6'd31) begin
            mem_addr = addr_full;
            if (fast_sel) begin
              ptr_d   = addr_full;
              state_d = DUMMY;
            end else begin
              data_sr_d = bus.i_mem_data;
              ptr_d     = addr_full + ADDR_BITS'(1);
              cnt_d     = '0;
              state_d   = DATA;
            end
          end
        end

`ifdef TEX_RESP_FAST_READ_EN
        DUMMY: begin
          // ptr already holds the start address, so mem_addr = A here.
          cnt_d = cnt + 6'd1;
          if (cnt == 6'd39) begin
            data_sr_d = bus.i_mem_data;
            ptr_d     = ptr + ADDR_BITS'(1);
            cnt_d     = '0;
            state_d   = DATA;
          end
        end
`endif

        DATA: begin
          // cnt counts shifts since the last load; the 8th edge reloads.
          if (cnt == 6'd7) begin
            data_sr_d = bus.i_mem_data;
            ptr_d     = ptr + ADDR_BITS'(1);
            cnt_d     = '0;
          end else begin
            data_sr_d = {data_sr[6:0], 1'b0};
            cnt_d     = cnt + 6'd1;
          end
        end

        IGNORE: begin
          state_d = IGNORE;
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    miso_d = (state_d == DATA) && data_sr_d[7];
  end

  assign bus.o_miso     = miso;
  assign bus.o_miso_oe  = (state == DATA) && !bus.i_csb;
  assign bus.o_mem_addr = mem_addr;
  assign bus.o_active   = (state != IDLE);
  assign bus.o_bad_cmd  = bad;

endmodule

// File: tb/tb_tex_flash_responder.sv
`timescale 1ns/1ps
module tb_tex_flash_responder;
  localparam int AB    = 12;
  localparam int MEM_N = 1 << AB;
  localparam int NV    = 9;

`ifdef TEX_RESP_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tex_flash_if #(.ADDR_BITS(AB)) bus ();

  tex_flash_responder #(.ADDR_BITS(AB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Asynchronous byte memory seen by the responder.
  logic [7:0] mem [0:MEM_N-1];
  assign bus.i_mem_data = mem[bus.o_mem_addr];

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          stop;     // >0: raise csb before edge 'stop'
    logic        exp_bad;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
  } vec_t;

  vec_t vecs [NV];

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]    rx [$];
  int            bad_hits, bad_edge, oe_hits, noise_hits;
  logic [AB-1:0] addr_at, reload_addr;
  logic          active_mid, active_after;
  logic [31:0]   hdr;
  int            silent;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] a, input int i);
    int idx;
    idx = ((int'(a) % MEM_N) + i) % MEM_N;
    return mem[idx];
  endfunction

  // One master transaction: header, nd dummy clocks, nbytes of data, then
  // deselect. Each bit is observed at the falling edge before the rising
  // edge on which the master would sample it.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] addr,
                     input int nd, input int nbytes, input int stop);
    logic [31:0] h;
    logic [7:0]  cur;
    int          total, d0;
    h  = {cmd, addr};
    cur = '0;
    d0 = 32 + nd;
    total = (stop > 0) ? stop : d0 + 8 * nbytes;
    rx.delete();
    bad_hits = 0; bad_edge = -1; oe_hits = 0; noise_hits = 0;
    active_mid = 1'b0; addr_at = '0; reload_addr = '0;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      if (k > 0 && bus.o_bad_cmd) begin
        bad_hits++;
        if (bad_edge < 0) bad_edge = k - 1;
      end
      if (k == 1) active_mid = bus.o_active;
      if (k > 0 && (bus.o_miso || bus.o_miso_oe)) noise_hits++;
      if (k >= d0 && k < total) begin
        cur = {cur[6:0], bus.o_miso};
        if (bus.o_miso_oe) oe_hits++;
        if (((k - d0) % 8) == 7) rx.push_back(cur);
        if (k == d0 + 7) reload_addr = bus.o_mem_addr;
      end
      if (k < total) begin
        bus.i_csb  = 1'b0;
        bus.i_mosi = (k < 32) ? h[31-k] : 1'($urandom_range(0, 1));
        if (k == 31 + nd) begin
          #1;
          addr_at = bus.o_mem_addr;
        end
      end else begin
        bus.i_csb  = 1'b1;
        bus.i_mosi = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    active_after = bus.o_active;
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nd, nb;
    logic        supported;

    reset_n    = 1'b0;
    bus.i_csb  = 1'b1;
    bus.i_mosi = 1'b0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'(i);

    vecs[0] = '{8'h03, 24'h000008, 0,  1'b0, 8'h08, 8'h09};
    vecs[1] = '{8'h03, 24'h000FFF, 0,  1'b0, 8'hFF, 8'h00};
    vecs[2] = '{8'h03, 24'hFF0FFF, 0,  1'b0, 8'hFF, 8'h00};
    vecs[3] = '{8'h9F, 24'h000000, 0,  1'b1, 8'h00, 8'h00};
    vecs[4] = '{8'h03, 24'h000100, 20, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{8'h03, 24'h000010, 0,  1'b0, 8'h10, 8'h11};
    vecs[6] = '{8'h0B, 24'h000020, 0,  !FAST, 8'h20, 8'h21};
    vecs[7] = '{8'h03, 24'h123456, 0,  1'b0, 8'h56, 8'h57};
    vecs[8] = '{8'h03, 24'h000040, 44, 1'b0, 8'h00, 8'h00};

    #22;
    chk("reset_miso",     32'(bus.o_miso),     0);
    chk("reset_miso_oe",  32'(bus.o_miso_oe),  0);
    chk("reset_active",   32'(bus.o_active),   0);
    chk("reset_bad_cmd",  32'(bus.o_bad_cmd),  0);
    chk("reset_mem_addr", 32'(bus.o_mem_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic READ, 64 data clocks.
    txn(8'h03, 24'h000008, 0, 8, 0);
    chk("basic_len", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      chk($sformatf("basic_byte%0d", i), 32'(rx[i]), 32'(8 + i));

    for (int i = 0; i < NV; i++) begin
      nd = (vecs[i].cmd == 8'h0B) ? 8 : 0;
      txn(vecs[i].cmd, vecs[i].addr, nd, 2, vecs[i].stop);
      chk($sformatf("vec%0d_bad_pulses", i), bad_hits, vecs[i].exp_bad ? 1 : 0);
      chk($sformatf("vec%0d_active_after", i), 32'(active_after), 0);
      if (vecs[i].exp_bad) begin
        chk($sformatf("vec%0d_bad_edge", i), bad_edge, 7);
        chk($sformatf("vec%0d_silent", i), noise_hits, 0);
      end else if (vecs[i].stop == 0) begin
        chk($sformatf("vec%0d_len", i), rx.size(), 2);
        if (rx.size() == 2) begin
          chk($sformatf("vec%0d_byte0", i), 32'(rx[0]), 32'(vecs[i].exp0));
          chk($sformatf("vec%0d_byte1", i), 32'(rx[1]), 32'(vecs[i].exp1));
        end
        chk($sformatf("vec%0d_addr_first", i), 32'(addr_at), int'(vecs[i].addr) % MEM_N);
        chk($sformatf("vec%0d_addr_reload", i), 32'(reload_addr),
            (int'(vecs[i].addr) % MEM_N + 1) % MEM_N);
        chk($sformatf("vec%0d_oe_cycles", i), oe_hits, 16);
        chk($sformatf("vec%0d_active_mid", i), 32'(active_mid), 1);
      end else begin
        chk($sformatf("vec%0d_abort_bytes", i), rx.size(), (vecs[i].stop > 32) ? (vecs[i].stop - 32) / 8 : 0);
      end
    end

    // Reset during byte index 2 (FFh) of a READ at 0FDh.
    hdr = {8'h03, 24'h0000FD};
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      bus.i_csb  = 1'b0;
      bus.i_mosi = (k < 32) ? hdr[31-k] : 1'b0;
      @(posedge clk);
    end
    #2;
    chk("pre_reset_miso", 32'(bus.o_miso), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_miso",     32'(bus.o_miso),     0);
    chk("async_rst_miso_oe",  32'(bus.o_miso_oe),  0);
    chk("async_rst_active",   32'(bus.o_active),   0);
    chk("async_rst_bad_cmd",  32'(bus.o_bad_cmd),  0);
    chk("async_rst_mem_addr", 32'(bus.o_mem_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    silent = 0;
    for (int k = 0; k < 20; k++) begin
      bus.i_mosi = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      if (bus.o_miso || bus.o_miso_oe || bus.o_bad_cmd) silent++;
    end
    chk("post_rst_silent", silent, 0);
    chk("post_rst_ignore_active", 32'(bus.o_active), 1);
    bus.i_csb = 1'b1;
    @(posedge clk);
    txn(8'h03, 24'h000000, 0, 2, 0);
    chk("post_rst_len", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("post_rst_byte0", 32'(rx[0]), 32'h00);
      chk("post_rst_byte1", 32'(rx[1]), 32'h01);
    end

    // Randomized transactions against the memory model.
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 30; t++) begin
      nd = $urandom_range(0, 9);
      if (nd < 6)      cmd = 8'h03;
      else if (nd < 8) cmd = 8'h0B;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h03 || cmd == 8'h0B) cmd = 8'h9F;
      end
      addr = 24'($urandom);
      if (t < 3) addr[11:0] = 12'hFFE;
      nb = $urandom_range(1, 4);
      nd = (cmd == 8'h0B) ? 8 : 0;
      supported = (cmd == 8'h03) || (FAST && cmd == 8'h0B);
      txn(cmd, addr, nd, nb, 0);
      chk($sformatf("rnd%0d_bad", t), bad_hits, supported ? 0 : 1);
      if (supported) begin
        chk($sformatf("rnd%0d_len", t), rx.size(), nb);
        for (int i = 0; i < nb && i < rx.size(); i++)
          chk($sformatf("rnd%0d_byte%0d", t, i), 32'(rx[i]), 32'(model_byte(addr, i)));
      end else begin
        chk($sformatf("rnd%0d_silent", t), noise_hits, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
